// File: rtl/sprite_snapshot.sv
// sprite_snapshot
//
// Bus initiator that, on each rising edge of vblank, reads the Pac-Man, ghost
// and world-map position/rotation registers into a staging buffer. It then
// (optionally) writes 0 to the frame lock register and publishes the whole
// buffer to the shadow outputs in a single edge, so the renderer always sees
// one coherent frame.
//
// Parameters
//   LOCK_RELEASE : 1 = write 0 to LOCK_ADDR after the reads, 0 = skip the write
//   LOCK_ADDR    : register address of the frame lock register
//
// Ports
//   i_clk, i_reset        : clock, synchronous active-low reset
//   i_vblank              : vblank level; only a rising edge starts a snapshot
//   i_ovr_clr             : clears o_overrun (a simultaneous set wins)
//   o_bus_req, i_bus_gnt  : register port request / grant (grant may drop any cycle)
//   o_reg_addr            : register address
//   o_reg_wdata, o_reg_we : write data / write strobe (strobe only with grant)
//   i_reg_rdata           : combinational read data for o_reg_addr
//   o_pac_*, o_map_*      : 8-bit shadows of regs 0,1,2 and 6,7
//   o_ghost_*             : four packed 8-bit shadows, ghost g in [8*g +: 8]
//   o_snap_valid          : sticky, set at the first commit after reset
//   o_snap_busy           : high whenever the engine is not idle
//   o_snap_done           : one-cycle pulse while in COMMIT
//   o_overrun             : sticky, a vblank rise arrived while busy

module sprite_snapshot #(
  parameter bit         LOCK_RELEASE = 1'b1,
  parameter logic [5:0] LOCK_ADDR    = 6'd32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_vblank,
  input  logic        i_ovr_clr,
  output logic        o_bus_req,
  input  logic        i_bus_gnt,
  output logic [5:0]  o_reg_addr,
  output logic [15:0] o_reg_wdata,
  output logic        o_reg_we,
  input  logic [15:0] i_reg_rdata,
  output logic [7:0]  o_pac_x,
  output logic [7:0]  o_pac_y,
  output logic [7:0]  o_pac_rot,
  output logic [7:0]  o_map_x,
  output logic [7:0]  o_map_y,
  output logic [31:0] o_ghost_x,
  output logic [31:0] o_ghost_y,
  output logic [31:0] o_ghost_rot,
  output logic        o_snap_valid,
  output logic        o_snap_busy,
  output logic        o_snap_done,
  output logic        o_overrun
);

  localparam int unsigned NumReads = 17;
  localparam logic [4:0]  LastIdx  = 5'd16;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRead,
    StUnlock,
    StCommit
  } state_e;

  // Staging slot k holds the register read at table index k.
  function automatic logic [5:0] read_addr(input logic [4:0] idx);
    logic [5:0] a;
    case (idx)
      5'd0:    a = 6'd0;
      5'd1:    a = 6'd1;
      5'd2:    a = 6'd2;
      5'd3:    a = 6'd6;
      5'd4:    a = 6'd7;
      5'd5:    a = 6'd8;
      5'd6:    a = 6'd9;
      5'd7:    a = 6'd10;
      5'd8:    a = 6'd14;
      5'd9:    a = 6'd15;
      5'd10:   a = 6'd16;
      5'd11:   a = 6'd20;
      5'd12:   a = 6'd21;
      5'd13:   a = 6'd22;
      5'd14:   a = 6'd26;
      5'd15:   a = 6'd27;
      5'd16:   a = 6'd28;
      default: a = 6'd0;
    endcase
    return a;
  endfunction

  state_e      r_state;
  logic [4:0]  r_idx;
  logic        r_vblank_q;
  logic        r_bus_req;
  logic [5:0]  r_reg_addr;
  logic        r_snap_valid;
  logic        r_snap_done;
  logic        r_overrun;
  logic [7:0]  r_staging [NumReads];
  logic [7:0]  r_pac_x;
  logic [7:0]  r_pac_y;
  logic [7:0]  r_pac_rot;
  logic [7:0]  r_map_x;
  logic [7:0]  r_map_y;
  logic [31:0] r_ghost_x;
  logic [31:0] r_ghost_y;
  logic [31:0] r_ghost_rot;

  logic w_start;
  logic w_unused_rdata;

  assign w_start        = i_vblank & ~r_vblank_q;
  assign w_unused_rdata = ^i_reg_rdata[15:8];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_vblank_q   <= 1'b0;
      r_bus_req    <= 1'b0;
      r_reg_addr   <= '0;
      r_snap_valid <= 1'b0;
      r_snap_done  <= 1'b0;
      r_overrun    <= 1'b0;
      r_pac_x      <= '0;
      r_pac_y      <= '0;
      r_pac_rot    <= '0;
      r_map_x      <= '0;
      r_map_y      <= '0;
      r_ghost_x    <= '0;
      r_ghost_y    <= '0;
      r_ghost_rot  <= '0;
      for (int i = 0; i < NumReads; i++) begin
        r_staging[i] <= '0;
      end
    end else begin
      r_vblank_q  <= i_vblank;
      r_snap_done <= 1'b0;

      // A vblank rise while busy is dropped but flagged; set beats clear.
      if (w_start && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end

      // bus_req, reg_addr and snap_done are registered, so each transition
      // loads the value the next state presents.
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state   <= StReq;
            r_bus_req <= 1'b1;
          end
        end
        StReq: begin
          if (i_bus_gnt) begin
            r_state    <= StRead;
            r_idx      <= '0;
            r_reg_addr <= read_addr(5'd0);
          end
        end
        StRead: begin
          // Without grant the address and index simply hold.
          if (i_bus_gnt) begin
            r_staging[r_idx] <= i_reg_rdata[7:0];
            if (r_idx == LastIdx) begin
              if (LOCK_RELEASE) begin
                r_state    <= StUnlock;
                r_reg_addr <= LOCK_ADDR;
              end else begin
                r_state     <= StCommit;
                r_bus_req   <= 1'b0;
                r_reg_addr  <= '0;
                r_snap_done <= 1'b1;
              end
            end else begin
              r_idx      <= r_idx + 5'd1;
              r_reg_addr <= read_addr(r_idx + 5'd1);
            end
          end
        end
        StUnlock: begin
          if (i_bus_gnt) begin
            r_state     <= StCommit;
            r_bus_req   <= 1'b0;
            r_reg_addr  <= '0;
            r_snap_done <= 1'b1;
          end
        end
        StCommit: begin
          // Every shadow updates on this one edge.
          r_state      <= StIdle;
          r_idx        <= '0;
          r_snap_valid <= 1'b1;
          r_pac_x      <= r_staging[0];
          r_pac_y      <= r_staging[1];
          r_pac_rot    <= r_staging[2];
          r_map_x      <= r_staging[3];
          r_map_y      <= r_staging[4];
          for (int g = 0; g < 4; g++) begin
            r_ghost_x[8*g +: 8]   <= r_staging[5 + 3*g];
            r_ghost_y[8*g +: 8]   <= r_staging[6 + 3*g];
            r_ghost_rot[8*g +: 8] <= r_staging[7 + 3*g];
          end
        end
        default: begin
          r_state   <= StIdle;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  // The write strobe must follow grant in the same cycle, so it stays
  // combinational on top of the registered state.
  assign o_reg_we     = (r_state == StUnlock) & i_bus_gnt;
  assign o_reg_wdata  = '0;
  assign o_bus_req    = r_bus_req;
  assign o_reg_addr   = r_reg_addr;
  assign o_snap_busy  = (r_state != StIdle);
  assign o_snap_done  = r_snap_done;
  assign o_snap_valid = r_snap_valid;
  assign o_overrun    = r_overrun;
  assign o_pac_x      = r_pac_x;
  assign o_pac_y      = r_pac_y;
  assign o_pac_rot    = r_pac_rot;
  assign o_map_x      = r_map_x;
  assign o_map_y      = r_map_y;
  assign o_ghost_x    = r_ghost_x;
  assign o_ghost_y    = r_ghost_y;
  assign o_ghost_rot  = r_ghost_rot;

endmodule

// File: tb/tb_sprite_snapshot.sv
// Testbench for sprite_snapshot: one instance with the lock release and one
// without, sharing stimulus and a behavioural register file.

module tb_sprite_snapshot;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, vblank, ovr_clr, gnt;

  logic        req_a, we_a, valid_a, busy_a, done_a, ovr_a;
  logic [5:0]  addr_a;
  logic [15:0] wdata_a, rdata_a;
  logic [7:0]  pac_x_a, pac_y_a, pac_rot_a, map_x_a, map_y_a;
  logic [31:0] gx_a, gy_a, gr_a;

  logic        req_b, we_b, valid_b, busy_b, done_b, ovr_b;
  logic [5:0]  addr_b;
  logic [15:0] wdata_b, rdata_b;
  logic [7:0]  pac_x_b, pac_y_b, pac_rot_b, map_x_b, map_y_b;
  logic [31:0] gx_b, gy_b, gr_b;

  logic [15:0] regs [64];
  logic [15:0] old_regs [64];

  always_comb rdata_a = regs[addr_a];
  always_comb rdata_b = regs[addr_b];

  sprite_snapshot u_dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_vblank(vblank), .i_ovr_clr(ovr_clr),
    .o_bus_req(req_a), .i_bus_gnt(gnt), .o_reg_addr(addr_a), .o_reg_wdata(wdata_a),
    .o_reg_we(we_a), .i_reg_rdata(rdata_a), .o_pac_x(pac_x_a), .o_pac_y(pac_y_a),
    .o_pac_rot(pac_rot_a), .o_map_x(map_x_a), .o_map_y(map_y_a), .o_ghost_x(gx_a),
    .o_ghost_y(gy_a), .o_ghost_rot(gr_a), .o_snap_valid(valid_a), .o_snap_busy(busy_a),
    .o_snap_done(done_a), .o_overrun(ovr_a)
  );

  sprite_snapshot #(.LOCK_RELEASE(1'b0)) u_dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_vblank(vblank), .i_ovr_clr(ovr_clr),
    .o_bus_req(req_b), .i_bus_gnt(gnt), .o_reg_addr(addr_b), .o_reg_wdata(wdata_b),
    .o_reg_we(we_b), .i_reg_rdata(rdata_b), .o_pac_x(pac_x_b), .o_pac_y(pac_y_b),
    .o_pac_rot(pac_rot_b), .o_map_x(map_x_b), .o_map_y(map_y_b), .o_ghost_x(gx_b),
    .o_ghost_y(gy_b), .o_ghost_rot(gr_b), .o_snap_valid(valid_b), .o_snap_busy(busy_b),
    .o_snap_done(done_b), .o_overrun(ovr_b)
  );

  // Shadow outputs flattened in read-table order: byte k = table index k.
  logic [135:0] flat_a, flat_b;
  always_comb begin
    flat_a = '0;
    flat_b = '0;
    flat_a[39:0] = {map_y_a, map_x_a, pac_rot_a, pac_y_a, pac_x_a};
    flat_b[39:0] = {map_y_b, map_x_b, pac_rot_b, pac_y_b, pac_x_b};
    for (int g = 0; g < 4; g++) begin
      flat_a[8*(5+3*g) +: 8] = gx_a[8*g +: 8];
      flat_a[8*(6+3*g) +: 8] = gy_a[8*g +: 8];
      flat_a[8*(7+3*g) +: 8] = gr_a[8*g +: 8];
      flat_b[8*(5+3*g) +: 8] = gx_b[8*g +: 8];
      flat_b[8*(6+3*g) +: 8] = gy_b[8*g +: 8];
      flat_b[8*(7+3*g) +: 8] = gr_b[8*g +: 8];
    end
  end

  int unsigned tbl [17] = '{0, 1, 2, 6, 7, 8, 9, 10, 14, 15, 16, 20, 21, 22, 26, 27, 28};

  int n_tests, n_fail, cyc;
  int done_a_cnt, done_a_cyc, done_b_cnt, done_b_cyc;
  int wr_cnt, wr_cyc, wr_nogrant, we_b_cnt, stall_bad;
  logic [5:0]   wr_addr;
  logic [15:0]  wr_data;
  logic [135:0] obs_commit, obs_final_a, obs_final_b, obs_rst_flat, exp_flat, prev_flat;
  logic         obs_rst_req, obs_rst_valid, obs_busy1, obs_req1;

  // Observe one cycle (outputs already settled), then advance to the next.
  task automatic tick();
    if (we_a === 1'b1) begin
      wr_cnt++;
      wr_cyc  = cyc;
      wr_addr = addr_a;
      wr_data = wdata_a;
      regs[addr_a] = wdata_a;
      if (gnt !== 1'b1) wr_nogrant++;
    end
    if (we_b === 1'b1) we_b_cnt++;
    if (done_a === 1'b1) begin done_a_cnt++; done_a_cyc = cyc; end
    if (done_b === 1'b1) begin done_b_cnt++; done_b_cyc = cyc; end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Cycle 0 = the cycle whose closing edge samples the vblank rise.
  task automatic run_snap(input int stall_idx, input int stall_n, input int mod_addr,
                          input int mod_cyc, input logic [15:0] mod_val, input int ovr_cyc,
                          input int rst_cyc, input int vb_low);
    int rc;
    logic [15:0] v;
    done_a_cnt = 0; done_a_cyc = -1; done_b_cnt = 0; done_b_cyc = -1;
    wr_cnt = 0; wr_cyc = -1; wr_nogrant = 0; we_b_cnt = 0; stall_bad = 0;
    wr_addr = '0; wr_data = '1;
    obs_commit = '1; obs_rst_flat = '1; obs_rst_req = 1'b1; obs_rst_valid = 1'b1;
    obs_busy1 = 1'b0; obs_req1 = 1'b0;
    rst_n = 1'b1; vblank = 1'b0; gnt = 1'b1; ovr_clr = 1'b0;
    #1;
    tick();
    old_regs = regs;
    cyc = 0;
    while (cyc < 24 + stall_n) begin
      if (cyc == 0) vblank = 1'b1;
      if (cyc == vb_low) vblank = 1'b0;
      if (ovr_cyc >= 0 && cyc == ovr_cyc) vblank = 1'b1;
      if (ovr_cyc >= 0 && cyc == ovr_cyc + 2) vblank = 1'b0;
      gnt = !(stall_n > 0 && cyc >= 2 + stall_idx && cyc < 2 + stall_idx + stall_n);
      if (mod_cyc >= 0 && cyc == mod_cyc) regs[mod_addr] = mod_val;
      rst_n = (cyc != rst_cyc);
      #1;
      if (!gnt && addr_a !== 6'(tbl[stall_idx])) stall_bad++;
      if (cyc == 1) begin obs_busy1 = busy_a; obs_req1 = req_a; end
      if (cyc == 20 + stall_n) obs_commit = flat_a;
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        obs_rst_flat  = flat_a | flat_b;
        obs_rst_req   = req_a | req_b;
        obs_rst_valid = valid_a | valid_b;
      end
      tick();
    end
    vblank = 1'b0;
    rst_n  = 1'b1;
    gnt    = 1'b1;
    obs_final_a = flat_a;
    obs_final_b = flat_b;
    // Reference: index k is read in cycle 2+k, pushed back by any stall before it.
    for (int k = 0; k < 17; k++) begin
      rc = 2 + k;
      if (stall_n > 0 && k >= stall_idx) rc += stall_n;
      v = old_regs[tbl[k]];
      if (mod_cyc >= 0 && int'(tbl[k]) == mod_addr && mod_cyc <= rc) v = mod_val;
      exp_flat[8*k +: 8] = v[7:0];
    end
    if (rst_cyc >= 0) exp_flat = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vblank = 1'b0; gnt = 1'b0; ovr_clr = 1'b0;
    #1;
    tick();
    tick();
    n_tests++;
    if (flat_a !== '0 || flat_b !== '0) begin
      n_fail++;
      $display("FAIL reset_shadows: got %h / %h expected 0", flat_a, flat_b);
    end
    n_tests++;
    if ({req_a, we_a, addr_a, wdata_a, valid_a, done_a, ovr_a, busy_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl_a: got %h expected 0",
               {req_a, we_a, addr_a, wdata_a, valid_a, done_a, ovr_a, busy_a});
    end
    n_tests++;
    if ({req_b, we_b, addr_b, wdata_b, valid_b, done_b, ovr_b, busy_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl_b: got %h expected 0",
               {req_b, we_b, addr_b, wdata_b, valid_b, done_b, ovr_b, busy_b});
    end
    rst_n = 1'b1;
    gnt   = 1'b1;
    #1;
    tick();
    n_tests++;
    if ({req_a, busy_a, req_b, busy_b} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b expected 0000", {req_a, busy_a, req_b, busy_b});
    end
    prev_flat = '0;
  endtask

  task automatic test_basic();
    for (int n = 0; n < 64; n++) regs[n] = 16'(n + 16'h40);
    regs[32] = 16'h0001;
    run_snap(0, 0, 0, -1, 16'h0, -1, -1, 5);
    n_tests++;
    if (pac_x_a !== 8'h40 || gx_a[31:24] !== 8'h5A || map_y_a !== 8'h47) begin
      n_fail++;
      $display("FAIL basic_values: got %h %h %h expected 40 5a 47", pac_x_a, gx_a[31:24],
               map_y_a);
    end
    n_tests++;
    if (obs_final_a !== exp_flat) begin
      n_fail++;
      $display("FAIL basic_shadow_a: got %h expected %h", obs_final_a, exp_flat);
    end
    n_tests++;
    if (done_a_cnt != 1 || done_a_cyc != 20) begin
      n_fail++;
      $display("FAIL basic_done_a: got %0d pulses at %0d expected 1 at 20", done_a_cnt,
               done_a_cyc);
    end
    n_tests++;
    if (wr_cnt != 1 || wr_cyc != 19 || wr_addr !== 6'd32 || wr_data !== 16'h0 || wr_nogrant != 0)
    begin
      n_fail++;
      $display("FAIL basic_unlock: got %0d writes at %0d addr %0d data %h expected 1 at 19 addr 32 data 0",
               wr_cnt, wr_cyc, wr_addr, wr_data);
    end
    n_tests++;
    if (regs[32] !== 16'h0) begin
      n_fail++;
      $display("FAIL basic_lock_reg: got %h expected 0", regs[32]);
    end
    n_tests++;
    if (obs_commit !== prev_flat || obs_busy1 !== 1'b1 || obs_req1 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_commit_hold: got %h busy %b req %b expected %h busy 1 req 1",
               obs_commit, obs_busy1, obs_req1, prev_flat);
    end
    n_tests++;
    if (valid_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid: got valid %b busy %b expected 1 0", valid_a, busy_a);
    end
    n_tests++;
    if (obs_final_b !== exp_flat || done_b_cnt != 1 || done_b_cyc != 19 || we_b_cnt != 0) begin
      n_fail++;
      $display("FAIL nolock_basic: got %h done %0d at %0d we %0d expected %h done 1 at 19 we 0",
               obs_final_b, done_b_cnt, done_b_cyc, we_b_cnt, exp_flat);
    end
    prev_flat = exp_flat;
  endtask

  task automatic test_grant_stall();
    for (int n = 0; n < 64; n++) regs[n] = 16'($urandom);
    regs[32] = 16'h0001;
    run_snap(5, 3, 0, -1, 16'h0, -1, -1, 5);
    n_tests++;
    if (stall_bad != 0) begin
      n_fail++;
      $display("FAIL stall_addr_hold: got %0d bad cycles expected 0", stall_bad);
    end
    n_tests++;
    if (done_a_cnt != 1 || done_a_cyc != 23 || done_b_cyc != 22) begin
      n_fail++;
      $display("FAIL stall_done: got %0d at %0d / b %0d expected 1 at 23 / b 22", done_a_cnt,
               done_a_cyc, done_b_cyc);
    end
    n_tests++;
    if (obs_final_a !== exp_flat || obs_final_b !== exp_flat || wr_cyc != 22) begin
      n_fail++;
      $display("FAIL stall_values: got %h / %h wr %0d expected %h wr 22", obs_final_a,
               obs_final_b, wr_cyc, exp_flat);
    end
    prev_flat = exp_flat;
  endtask

  task automatic test_atomicity();
    regs[0]  = 16'h1240;
    regs[32] = 16'h0001;
    run_snap(0, 0, 0, 10, 16'h0099, -1, -1, 5);
    n_tests++;
    if (obs_commit !== prev_flat) begin
      n_fail++;
      $display("FAIL atomic_hold: got %h expected %h", obs_commit, prev_flat);
    end
    n_tests++;
    if (pac_x_a !== 8'h40 || obs_final_a !== exp_flat) begin
      n_fail++;
      $display("FAIL atomic_value: got pac_x %h shadow %h expected 40 %h", pac_x_a, obs_final_a,
               exp_flat);
    end
    prev_flat = exp_flat;
  endtask

  task automatic test_overrun();
    regs[32] = 16'h0001;
    run_snap(0, 0, 0, -1, 16'h0, 10, -1, 5);
    n_tests++;
    if (ovr_a !== 1'b1 || ovr_b !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b %b expected 1 1", ovr_a, ovr_b);
    end
    n_tests++;
    if (done_a_cnt != 1 || done_b_cnt != 1 || obs_final_a !== exp_flat) begin
      n_fail++;
      $display("FAIL overrun_single: got %0d / %0d pulses shadow %h expected 1 / 1 %h",
               done_a_cnt, done_b_cnt, obs_final_a, exp_flat);
    end
    ovr_clr = 1'b1;
    #1;
    tick();
    ovr_clr = 1'b0;
    n_tests++;
    if (ovr_a !== 1'b0 || ovr_b !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b %b expected 0 0", ovr_a, ovr_b);
    end
    prev_flat = exp_flat;
  endtask

  task automatic test_reset_midop();
    regs[32] = 16'h0001;
    run_snap(0, 0, 0, -1, 16'h0, -1, 12, 5);
    n_tests++;
    if (obs_rst_flat !== '0 || obs_rst_req !== 1'b0 || obs_rst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_after: got %h req %b valid %b expected 0 0 0", obs_rst_flat,
               obs_rst_req, obs_rst_valid);
    end
    n_tests++;
    if (done_a_cnt != 0 || done_b_cnt != 0 || wr_cnt != 0 || regs[32] !== 16'h0001) begin
      n_fail++;
      $display("FAIL midreset_abort: got done %0d / %0d writes %0d lock %h expected 0 0 0 1",
               done_a_cnt, done_b_cnt, wr_cnt, regs[32]);
    end
    n_tests++;
    if (obs_final_a !== exp_flat || obs_final_b !== exp_flat || valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_final: got %h / %h valid %b expected 0 0 0", obs_final_a,
               obs_final_b, valid_a);
    end
    prev_flat = exp_flat;
  endtask

  task automatic test_random();
    int s_idx, s_n, m_addr, m_cyc;
    for (int it = 0; it < 6; it++) begin
      for (int n = 0; n < 64; n++) regs[n] = 16'($urandom);
      regs[32] = 16'h0001;
      s_idx  = int'($urandom_range(0, 16));
      s_n    = int'($urandom_range(0, 4));
      m_addr = int'(tbl[$urandom_range(0, 16)]);
      m_cyc  = int'($urandom_range(1, 22));
      // vblank stays high for the whole run: it must not retrigger.
      run_snap(s_idx, s_n, m_addr, m_cyc, 16'($urandom), -1, -1, 1000);
      n_tests++;
      if (obs_final_a !== exp_flat || obs_final_b !== exp_flat || obs_commit !== prev_flat) begin
        n_fail++;
        $display("FAIL random_values it%0d: got %h / %h commit %h expected %h commit %h", it,
                 obs_final_a, obs_final_b, obs_commit, exp_flat, prev_flat);
      end
      n_tests++;
      if (done_a_cnt != 1 || done_a_cyc != 20 + s_n || done_b_cnt != 1 ||
          done_b_cyc != 19 + s_n || stall_bad != 0) begin
        n_fail++;
        $display("FAIL random_timing it%0d: got %0d at %0d / %0d at %0d stall %0d expected 1 at %0d / 1 at %0d stall 0",
                 it, done_a_cnt, done_a_cyc, done_b_cnt, done_b_cyc, stall_bad, 20 + s_n,
                 19 + s_n);
      end
      n_tests++;
      if (wr_cnt != 1 || wr_cyc != 19 + s_n || wr_nogrant != 0 || we_b_cnt != 0 ||
          ovr_a !== 1'b0) begin
        n_fail++;
        $display("FAIL random_unlock it%0d: got %0d at %0d nogrant %0d b %0d ovr %b expected 1 at %0d 0 0 0",
                 it, wr_cnt, wr_cyc, wr_nogrant, we_b_cnt, ovr_a, 19 + s_n);
      end
      prev_flat = exp_flat;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    vblank  = 1'b0;
    ovr_clr = 1'b0;
    gnt     = 1'b0;
    prev_flat = '0;
    exp_flat  = '0;
    for (int n = 0; n < 64; n++) regs[n] = 16'h0;
    test_reset();
    test_basic();
    test_grant_stall();
    test_atomicity();
    test_overrun();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_snapshot.md
# sprite_snapshot

Bus initiator on the sprite register bus that, at the start of each vertical blank, reads the Pac-Man, ghost and world-map position/rotation registers into a staging buffer and releases the CPU's frame lock. It then publishes the buffer atomically as a shadow copy for the renderer. It sits between the video timing generator and the sprite register file, sharing the register port with the CPU through a request/grant arbiter. The renderer always sees one coherent frame, never a half-updated one.

## Interface
- `LOCK_RELEASE`, default 1: 1 = write 0 to frame lock register (addr 32) after the reads; 0 = skip that write.
- `LOCK_ADDR`, default 32: register address of the frame lock register.
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-low (0 = reset).
- `vblank` in 1: level from video timing; only its rising edge starts a snapshot.
- `ovr_clr` in 1: clears `overrun`.
- `bus_req` out 1: request for the register port.
- `bus_gnt` in 1: grant from the arbiter; may drop at any cycle.
- `reg_addr` out 6: register address.
- `reg_wdata` out 16: write data.
- `reg_we` out 1: write strobe.
- `reg_rdata` in 16: combinational read data for `reg_addr`, valid in the same cycle.
- `pac_x`, `pac_y`, `pac_rot` out 8 each: shadow of regs 0, 1, 2.
- `map_x`, `map_y` out 8 each: shadow of regs 6, 7.
- `ghost_x`, `ghost_y`, `ghost_rot` out 32 each: packed `[8*g+:8]`.
  - g=0 Blinky: regs 8, 9, 10.
  - g=1 Pinky: regs 14, 15, 16.
  - g=2 Inky: regs 20, 21, 22.
  - g=3 Clyde: regs 26, 27, 28.
- `snap_valid` out 1: set at the first commit after reset, sticky.
- `snap_busy` out 1: high in every state except IDLE.
- `snap_done` out 1: one-cycle pulse in COMMIT.
- `overrun` out 1: sticky; set when a `vblank` rise arrives while busy.

## Operation
- Read sequence is a fixed 17-entry table, index 0..16: 0, 1, 2, 6, 7, 8, 9, 10, 14, 15, 16, 20, 21, 22, 26, 27, 28.
- Only `reg_rdata[7:0]` is captured.
- Edge detect: `vblank_q` registers `vblank`. `start` = `vblank & ~vblank_q`.
- States:
  - **IDLE**: `bus_req` = 0. On `start`, go to REQ.
  - **REQ**: `bus_req` = 1. If `bus_gnt`, go to READ with index = 0; else stay.
  - **READ**: `bus_req` = 1, `reg_addr` = table[index].
    - If `bus_gnt`: capture into `staging[index]`. If index = 16, go to UNLOCK (or COMMIT when `LOCK_RELEASE` = 0); else index += 1.
    - If `!bus_gnt`: no capture and index holds (pause). Resume when grant returns.
  - **UNLOCK**: `bus_req` = 1, `reg_addr` = `LOCK_ADDR`, `reg_wdata` = 0, `reg_we` = `bus_gnt`. On `bus_gnt`, go to COMMIT; else stay.
  - **COMMIT**: `bus_req` = 0. All shadow outputs load from staging in the same edge. `snap_done` = 1, `snap_valid` <= 1. Next state IDLE.
- Outside READ/UNLOCK: `reg_addr` = 0, `reg_wdata` = 0, `reg_we` = 0.
- `reg_we` is never asserted without `bus_gnt`.
- `start` while not IDLE: ignored (no restart), `overrun` <= 1.
- `ovr_clr` and a set in the same cycle: set wins.
- Staging never drives outputs directly. Shadows change only on the COMMIT edge.

## Timing
- Reset (`reset` = 0 at an edge):
  - State IDLE, index 0, `vblank_q` 0.
  - All shadows, staging, `snap_valid`, `snap_done`, `overrun`, `bus_req`, `reg_we`, `reg_addr` and `reg_wdata` are 0.
  - Reset mid-snapshot aborts without commit. The shadows are cleared, and `bus_req` is low in the cycle after the reset edge.
- With grant held and `vblank` rising at cycle 0 (sampled at edge 0):
  - Cycle 1: REQ.
  - Cycles 2..18: READ.
  - Cycle 19: UNLOCK.
  - Cycle 20: COMMIT (`snap_done` high).
  - Cycle 21: shadows visible.
- Total latency: 21 cycles, or 20 with `LOCK_RELEASE` = 0.
- Each grant-low cycle in REQ/READ/UNLOCK adds exactly one cycle.
- A `vblank` held high does not retrigger. It needs a low-then-high transition.

## Test plan
- **Basic snapshot**: preload reg n = n+0x40, hold grant, pulse `vblank`.
  - Expect `pac_x` = 0x40, `ghost_x[31:24]` = 0x5A, `map_y` = 0x47.
  - Expect `snap_done` at cycle 20 and a single write of 0 to addr 32 at cycle 19.
- **Grant stall**: drop `bus_gnt` for 3 cycles at READ index 5.
  - Expect `reg_addr` to hold at 8, no capture, `snap_done` at cycle 23, and correct values.
- **Atomicity**: change reg 0 to 0x99 between index 0 and commit.
  - Expect `pac_x` to keep its old value until the commit edge, then take the value read at index 0.
- **Overrun**: second `vblank` rise at cycle 10.
  - Expect `overrun` = 1 and only one `snap_done`.
  - `ovr_clr` then clears it.
- **Reset mid-op**: assert `reset` = 0 at cycle 12.
  - Expect all outputs 0, `bus_req` 0 next cycle, `snap_valid` 0, and no write to addr 32.
- **`LOCK_RELEASE` = 0**: `reg_we` never asserted and `snap_done` at cycle 19.
